// File: rtl/bcd_button_counter.sv
// rtl/bcd_button_counter.sv - debounced up/down/clear buttons driving a two-digit BCD counter
module bcd_button_counter #(
    parameter int CLK_DIV    = 100_000,
    parameter int DB_SAMPLES = 10,
    parameter int MAX_COUNT  = 99
) (
    input  logic       CLK100MHZ,
    input  logic       RST,
    input  logic       BTNU,
    input  logic       BTND,
    input  logic       BTNC,
    output logic [3:0] TENS,
    output logic [3:0] ONES,
    output logic       CHANGED,
    output logic       WRAP
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RUN_W = $clog2(DB_SAMPLES + 1);
    localparam logic [3:0] MAX_TENS = 4'(MAX_COUNT / 10);
    localparam logic [3:0] MAX_ONES = 4'(MAX_COUNT % 10);

    // Button index: 0 = up, 1 = down, 2 = clear.
    logic [2:0]            btn_raw;
    logic [2:0]            sync1_q;
    logic [2:0]            sync2_q;
    logic [DIV_W-1:0]      div_q;
    logic [DIV_W-1:0]      div_d;
    logic                  tick;
    logic [2:0]            lvl_q;
    logic [2:0]            lvl_d;
    logic [2:0][RUN_W-1:0] run_q;
    logic [2:0][RUN_W-1:0] run_d;
    logic [2:0]            lvl_dly_q;
    logic [2:0]            press_q;
    logic [3:0]            tens_q;
    logic [3:0]            tens_d;
    logic [3:0]            ones_q;
    logic [3:0]            ones_d;
    logic                  changed_q;
    logic                  changed_d;
    logic                  wrap_q;
    logic                  wrap_d;
    logic                  at_max;
    logic                  at_zero;

    assign btn_raw = {BTNC, BTND, BTNU};

    assign tick  = (div_q == DIV_W'(CLK_DIV - 1));
    assign div_d = tick ? '0 : div_q + DIV_W'(1);

    always_comb begin
        lvl_d = lvl_q;
        run_d = run_q;
        for (int i = 0; i < 3; i++) begin
            if (tick) begin
                if (sync2_q[i] != lvl_q[i]) begin
                    if (run_q[i] == RUN_W'(DB_SAMPLES - 1)) begin
                        lvl_d[i] = ~lvl_q[i];
                        run_d[i] = '0;
                    end else begin
                        run_d[i] = run_q[i] + RUN_W'(1);
                    end
                end else begin
                    run_d[i] = '0;
                end
            end
        end
    end

    assign at_max  = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
    assign at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

    // Clear beats everything; simultaneous up and down cancel.
    always_comb begin
        tens_d    = tens_q;
        ones_d    = ones_q;
        changed_d = 1'b0;
        wrap_d    = 1'b0;
        if (press_q[2]) begin
            tens_d    = 4'd0;
            ones_d    = 4'd0;
            changed_d = ~at_zero;
        end else if (press_q[0] && press_q[1]) begin
            changed_d = 1'b0;
        end else if (press_q[0]) begin
            changed_d = 1'b1;
            if (at_max) begin
                tens_d = 4'd0;
                ones_d = 4'd0;
                wrap_d = 1'b1;
            end else if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end else if (press_q[1]) begin
            changed_d = 1'b1;
            if (at_zero) begin
                tens_d = MAX_TENS;
                ones_d = MAX_ONES;
                wrap_d = 1'b1;
            end else if (ones_q == 4'd0) begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
            end else begin
                ones_d = ones_q - 4'd1;
            end
        end
    end

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            div_q     <= '0;
            lvl_q     <= '0;
            run_q     <= '0;
            lvl_dly_q <= '0;
            press_q   <= '0;
            tens_q    <= '0;
            ones_q    <= '0;
            changed_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            div_q     <= div_d;
            lvl_q     <= lvl_d;
            run_q     <= run_d;
            lvl_dly_q <= lvl_q;
            press_q   <= lvl_q & ~lvl_dly_q;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            changed_q <= changed_d;
            wrap_q    <= wrap_d;
        end
    end

    assign TENS    = tens_q;
    assign ONES    = ones_q;
    assign CHANGED = changed_q;
    assign WRAP    = wrap_q;

endmodule
